// File: rtl/comparador_sweep_ctrl.sv
// comparador_sweep_ctrl
//
// Sequencer that drives the 4-input composite-number comparator through an
// operand range [lo, hi]. Each operand is held on A..D for SETTLE cycles.
// The comparator result S is then sampled into a per-operand mask and a
// running count. A one-cycle done pulse ends every sweep. This includes a
// rejected sweep where lo > hi, which raises err instead of sampling.
//
// Parameters:
//   SETTLE  cycles each operand is held before S is sampled (1..15)
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   sweep request, only honoured in IDLE
//   lo     in   4   first operand, captured on an accepted start
//   hi     in   4   last operand (inclusive), captured on an accepted start
//   A..D   out  1   comparator operand, A = MSB
//   S      in   1   comparator result
//   busy   out  1   high while operands are being swept
//   done   out  1   one-cycle end-of-sweep pulse
//   err    out  1   last accepted start had lo > hi
//   count  out  5   number of sampled operands with S = 1
//   mask   out  16  bit k = sampled S for operand k
module comparador_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  lo,
    input  logic [3:0]  hi,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        S,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  count,
    output logic [15:0] mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] W_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] hi_q;
    logic [3:0] cur;
    logic [3:0] w;
    logic       accept;
    logic       sample_now;
    logic       range_bad;

    assign range_bad = (lo > hi);

    // State register; reset aborts any sweep without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs. The operand is driven only in RUN, so A..D
    // fall back to zero as soon as the sweep leaves RUN.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        sample_now   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        {A, B, C, D} = 4'b0000;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = range_bad ? FIN : RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                {A, B, C, D} = cur;
                if (w == W_LAST) begin
                    sample_now = 1'b1;
                    // Terminate on cur == hi before incrementing so hi = 15 never wraps
                    if (cur == hi_q) begin
                        state_next = FIN;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: capture on accept, settle counting and result sampling in RUN.
    // Results are left untouched outside an accepted start so they hold after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= 4'd0;
            cur   <= 4'd0;
            w     <= 4'd0;
            count <= 5'd0;
            mask  <= 16'h0000;
            err   <= 1'b0;
        end else if (accept) begin
            hi_q  <= hi;
            cur   <= lo;
            w     <= 4'd0;
            count <= 5'd0;
            mask  <= 16'h0000;
            err   <= range_bad;
        end else if (state == RUN) begin
            if (sample_now) begin
                mask[cur] <= S;
                count     <= count + {4'b0000, S};
                w         <= 4'd0;
                if (cur != hi_q) begin
                    cur <= cur + 4'd1;
                end
            end else begin
                w <= w + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_comparador_sweep_ctrl.sv
// tb_comparador_sweep_ctrl
//
// Drives two sequencer instances (SETTLE = 1 and SETTLE = 3) from the same
// stimulus. Each instance has its own comparator model: a lookup table
// indexed by the operand the instance presents. Expected timing and results
// come from the sweep rules written as plain arithmetic.
module tb_comparador_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [15:0] lutBits;

    logic        a1, b1, c1, d1, s1, busy1, done1, err1;
    logic [4:0]  count1;
    logic [15:0] mask1;
    logic        a3, b3, c3, d3, s3, busy3, done3, err3;
    logic [4:0]  count3;
    logic [15:0] mask3;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Comparator model for each instance: S is the table entry for ABCD
    assign s1 = lutBits[{a1, b1, c1, d1}];
    assign s3 = lutBits[{a3, b3, c3, d3}];

    comparador_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .A(a1), .B(b1), .C(c1), .D(d1), .S(s1),
        .busy(busy1), .done(done1), .err(err1), .count(count1), .mask(mask1)
    );

    comparador_sweep_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .A(a3), .B(b3), .C(c3), .D(d3), .S(s3),
        .busy(busy3), .done(done3), .err(err3), .count(count3), .mask(mask3)
    );

    // Single comparison point: counts the comparison and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected per-cycle view k cycles after the start edge. Operand j is shown
    // for s cycles, and done follows the last operand. Everything reads zero
    // after a reset.
    task automatic checkCycle(input int s, input int n, input int l, input int k,
                              input int rstAt, input logic bz, input logic dn,
                              input logic [3:0] op);
        int eb, ed, eop;
        eb = 0; ed = 0; eop = 0;
        if (rstAt == 0 || k <= rstAt) begin
            if (k <= n * s) begin
                eb  = 1;
                eop = l + (k - 1) / s;
            end else if (k == n * s + 1) begin
                ed = 1;
            end
        end
        checkOutput($sformatf("S%0d_k%0d_busy", s, k), 32'(bz), 32'(eb));
        checkOutput($sformatf("S%0d_k%0d_done", s, k), 32'(dn), 32'(ed));
        checkOutput($sformatf("S%0d_k%0d_operand", s, k), 32'(op), 32'(eop));
    endtask

    // Expected results: table entries inside [l, h], nothing when the range is bad or reset hit
    task automatic checkFinal(input int s, input int l, input int h, input bit wasReset,
                              input logic [4:0] cnt, input logic [15:0] msk, input logic er);
        int ecount;
        logic [15:0] emask;
        int eerr;
        ecount = 0; emask = 16'h0000; eerr = 0;
        if (!wasReset) begin
            eerr = (l > h) ? 1 : 0;
            for (int v = 0; v < 16; v++) begin
                if (v >= l && v <= h && lutBits[v]) begin
                    emask[v] = 1'b1;
                    ecount++;
                end
            end
        end
        checkOutput($sformatf("S%0d_lo%0d_hi%0d_count", s, l, h), 32'(cnt), 32'(ecount));
        checkOutput($sformatf("S%0d_lo%0d_hi%0d_mask", s, l, h), 32'(msk), 32'(emask));
        checkOutput($sformatf("S%0d_lo%0d_hi%0d_err", s, l, h), 32'(er), 32'(eerr));
    endtask

    // One sweep request issued at the current falling edge, followed cycle by
    // cycle until both instances are back in IDLE. lo/hi are scrambled during
    // the sweep. Extra start pulses are only sent while the fast instance is
    // still in RUN or FIN.
    task automatic applyStimulus(input logic [3:0] l, input logic [3:0] h,
                                 input int rstAt, input bit pester);
        int n;
        n = (l > h) ? 0 : int'(h) - int'(l) + 1;
        $display("[TB] sweep lo=%0d hi=%0d rstAt=%0d pester=%0d", l, h, rstAt, pester);
        lo    = l;
        hi    = h;
        start = 1'b1;
        for (int k = 1; k <= 3 * n + 3; k++) begin
            @(negedge clk);
            checkCycle(1, n, int'(l), k, rstAt, busy1, done1, {a1, b1, c1, d1});
            checkCycle(3, n, int'(l), k, rstAt, busy3, done3, {a3, b3, c3, d3});
            if (pester && k <= n + 1) begin
                start = (k == 3 || k == 8) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            lo  = 4'($urandom);
            hi  = 4'($urandom);
            rst = (rstAt != 0 && k == rstAt);
        end
        checkFinal(1, int'(l), int'(h), rstAt != 0, count1, mask1, err1);
        checkFinal(3, int'(l), int'(h), rstAt != 0, count3, mask3, err3);
    endtask

    initial begin
        logic [3:0] rl, rh, tmp;
        rst     = 1'b1;
        start   = 1'b0;
        lo      = 4'd0;
        hi      = 4'd0;
        lutBits = 16'hD750;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy1", 32'(busy1), 32'd0);
        checkOutput("reset_done1", 32'(done1), 32'd0);
        checkOutput("reset_err1", 32'(err1), 32'd0);
        checkOutput("reset_count1", 32'(count1), 32'd0);
        checkOutput("reset_mask1", 32'(mask1), 32'd0);
        checkOutput("reset_operand1", 32'({a1, b1, c1, d1}), 32'd0);
        checkOutput("reset_busy3", 32'(busy3), 32'd0);
        checkOutput("reset_done3", 32'(done3), 32'd0);
        checkOutput("reset_count3", 32'(count3), 32'd0);
        checkOutput("reset_mask3", 32'(mask3), 32'd0);
        rst = 1'b0;

        applyStimulus(4'd0, 4'd15, 0, 1'b0);
        checkOutput("full_count_const", 32'(count1), 32'd8);
        checkOutput("full_mask_const", 32'(mask1), 32'hD750);
        applyStimulus(4'd4, 4'd9, 0, 1'b0);
        checkOutput("mid_mask_const", 32'(mask1), 32'h0350);
        applyStimulus(4'd9, 4'd9, 0, 1'b0);
        checkOutput("single_mask_const", 32'(mask3), 32'h0200);
        applyStimulus(4'd10, 4'd3, 0, 1'b0);
        applyStimulus(4'd2, 4'd5, 0, 1'b0);
        applyStimulus(4'd0, 4'd15, 5, 1'b0);
        applyStimulus(4'd0, 4'd15, 0, 1'b0);
        applyStimulus(4'd0, 4'd15, 0, 1'b1);
        checkOutput("pester_count_const", 32'(count1), 32'd8);

        for (int it = 0; it < 10; it++) begin
            lutBits = 16'($urandom);
            rl = 4'($urandom);
            rh = 4'($urandom);
            if (it < 7 && rl > rh) begin
                tmp = rl; rl = rh; rh = tmp;
            end
            applyStimulus(rl, rh, 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/comparador_sweep_ctrl.md
Name: comparador_sweep_ctrl

Overview:
- Sequencer for the 4-input composite-number comparator (inputs A,B,C,D with A as MSB; output S = 1 when the value ABCD is composite).
- On a start request it sweeps an operand range [lo, hi] through the comparator, one value at a time. It holds each value for a programmable settle time, then samples S.
- It accumulates a per-value result mask and a count of composites, and signals completion with a one-cycle done pulse.
- It replaces free-running testbench loops as the in-design driver of the comparator.

Parameters:
- SETTLE, default 1: cycles each operand is held on A..D before S is sampled. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  sweep request; sampled in IDLE only
- lo  in  4  first operand of the sweep; captured on an accepted start
- hi  in  4  last operand of the sweep, inclusive; captured on an accepted start
- A  out  1  comparator operand bit 3 (MSB)
- B  out  1  comparator operand bit 2
- C  out  1  comparator operand bit 1
- D  out  1  comparator operand bit 0 (LSB)
- S  in  1  comparator result
- busy  out  1  high while the sweep is in progress
- done  out  1  one-cycle pulse when the sweep ends (including the error case)
- err  out  1  high when the last start had lo > hi; held until the next accepted start or rst
- count  out  5  number of sampled values with S = 1 (range 0..16)
- mask  out  16  bit k = sampled S for operand k; bits outside [lo, hi] = 0

Behaviour:
- Reset: rst high at a rising edge forces the following, regardless of state:
  - state = IDLE
  - A = B = C = D = 0
  - busy = 0, done = 0, err = 0
  - count = 0, mask = 16'h0000
  - settle counter = 0
  - Reset mid-sweep aborts the sweep; no done pulse is issued.
- States: IDLE, RUN, FIN.
- IDLE:
  - A..D = 0, busy = 0.
  - If start = 1 at edge t: capture lo and hi, clear count, mask and err, and set w = 0.
    - If lo > hi: set err = 1, go to FIN (done = 1 in cycle t+1, nothing is sampled).
    - Else: set cur = lo and go to RUN.
- RUN:
  - busy = 1 and {A,B,C,D} = cur.
  - Each cycle, w increments.
  - When w == SETTLE-1, at that edge:
    - mask[cur] <= S; count <= count + S.
    - If cur == hi, go to FIN.
    - Else cur <= cur + 1 and w <= 0.
- FIN: done = 1 and busy = 0 for exactly one cycle, then return to IDLE.
- Timing (N = hi - lo + 1):
  - busy is high in cycles t+1 .. t+N*SETTLE.
  - The first operand appears in cycle t+1.
  - done is high in cycle t+N*SETTLE+1.
  - The next start is accepted in the cycle after done.
- Wrap-around:
  - The termination test is cur == hi, made before the increment. For hi = 15, cur never wraps to 0.
  - count is 5 bits so that 16 composites-or-ones cannot overflow.
- start while in RUN or FIN is ignored and has no side effects.
- count, mask and err are held after done until the next accepted start or rst.
- A..D return to 0 on entry to FIN/IDLE.
- The lo and hi inputs may change during a sweep without effect; the captured copies are used.

Test Plan:
- SETTLE=1; rst, then start with lo=0, hi=15 -> done in cycle 17; busy high in cycles 1..16; count=8; mask=16'hD750 (operands 4,6,8,9,10,12,14,15). No wrap: A..D=0 after done.
- SETTLE=1; lo=4, hi=9 -> N=6; done 7 cycles after start; count=4; mask=16'h0350.
- SETTLE=3; lo=hi=9 -> A..D=1001 held for 3 cycles; done 4 cycles after start; count=1; mask=16'h0200.
- lo=10, hi=3 -> err=1; done in cycle t+1; busy never high; count=0; mask=0. The next valid start clears err.
- SETTLE=1; full sweep with rst asserted at cycle 5 -> cycle 6 shows all outputs zero and state IDLE; no done pulse. A new start then runs cleanly with count=8.
- start pulsed again in cycles 3 and 8 of a full sweep -> ignored; results are identical to the first scenario; a single done pulse.
